// File: rtl/joy_input_conditioner.sv
// Joystick/pause conditioner: sync, debounce, direction arbitration, pause toggle.
// Optional JOY_DIR_LATCH_EN holds the last pressed direction after release.
module joy_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic joy_n,
    input  logic joy_e,
    input  logic joy_s,
    input  logic joy_w,
    input  logic pause_btn,
    output logic dir_up,
    output logic dir_right,
    output logic dir_down,
    output logic dir_left,
    output logic dir_change,
    output logic paused
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_RIGHT,
        S_DOWN,
        S_LEFT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       REL     = {5{ACTIVE_LOW}};

    // Line index: 0 up, 1 right, 2 down, 3 left, 4 pause
    logic [4:0]       raw;
    logic [4:0]       sync1_q, sync2_q, synced;
    logic [4:0]       stable_q, stable_d, stable_dly_q;
    logic [4:0]       press;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    state_t     state_q, state_d;
    logic       paused_q, paused_d;
    logic [3:0] dirs_q, dirs_d;
    logic       change_q;
    logic       release_evt;

    assign raw    = {pause_btn, joy_w, joy_s, joy_e, joy_n};
    assign synced = sync2_q ^ REL;
    assign press  = stable_q & ~stable_dly_q;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    function automatic state_t pick(input logic [3:0] v);
        if (v[0]) return S_UP;
        if (v[1]) return S_RIGHT;
        if (v[2]) return S_DOWN;
        if (v[3]) return S_LEFT;
        return S_IDLE;
    endfunction

    function automatic logic [3:0] decode(input state_t s);
        logic [3:0] d;
        d = 4'b0000;
        unique case (s)
            S_UP:    d = 4'b0001;
            S_RIGHT: d = 4'b0010;
            S_DOWN:  d = 4'b0100;
            S_LEFT:  d = 4'b1000;
            default: d = 4'b0000;
        endcase
        return d;
    endfunction

`ifdef JOY_DIR_LATCH_EN
    assign release_evt = 1'b0;
`else
    logic cur_held;

    always_comb begin
        cur_held = 1'b1;
        unique case (state_q)
            S_UP:    cur_held = stable_q[0];
            S_RIGHT: cur_held = stable_q[1];
            S_DOWN:  cur_held = stable_q[2];
            S_LEFT:  cur_held = stable_q[3];
            default: cur_held = 1'b1;
        endcase
    end

    assign release_evt = ~cur_held;
`endif

    // Frozen while paused; new presses beat release re-evaluation
    always_comb begin
        state_d = state_q;
        if (!paused_q) begin
            if (|press[3:0]) begin
                state_d = pick(press[3:0]);
            end else if (release_evt) begin
                state_d = pick(stable_q[3:0]);
            end
        end
        paused_d = paused_q ^ press[4];
        dirs_d   = paused_d ? 4'b0000 : decode(state_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= REL;
            sync2_q      <= REL;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            state_q      <= S_IDLE;
            paused_q     <= 1'b0;
            dirs_q       <= 4'b0000;
            change_q     <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            paused_q     <= paused_d;
            dirs_q       <= dirs_d;
            change_q     <= (dirs_d != dirs_q);
        end
    end

    assign dir_up     = dirs_q[0];
    assign dir_right  = dirs_q[1];
    assign dir_down   = dirs_q[2];
    assign dir_left   = dirs_q[3];
    assign dir_change = change_q;
    assign paused     = paused_q;

endmodule
